// File: rtl/key_debouncer_pkg.sv
// Shared definitions for the key conditioner: repeat FSM encoding, default
// timing derived from the board clock, and counter sizing.
package key_debouncer_pkg;

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        HOLD_DELAY  = 2'd1,
        HOLD_REPEAT = 2'd2
    } rpt_state_e;

    localparam int unsigned CLK_FREQ_HZ       = 50_000_000;
    localparam int unsigned DEBOUNCE_DEFAULT  = CLK_FREQ_HZ / 100;   // 10 ms
    localparam int unsigned REP_DELAY_DEFAULT = CLK_FREQ_HZ / 2;     // 500 ms
    localparam int unsigned REP_PERIOD_DEFAULT = CLK_FREQ_HZ / 10;   // 100 ms

    // Width of a counter that must hold 0..n; never narrower than one bit.
    function automatic int cnt_width(input int unsigned n);
        return (n == 0) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchronizer, debounce counter and auto-repeat FSM.
//
// state       | meaning
// RELEASED    | key up, or repeat disabled; press emits the first repeat pulse
// HOLD_DELAY  | key held, counting the initial delay before repeating
// HOLD_REPEAT | key held, emitting a repeat pulse every REPEAT_PERIOD cycles
module key_debounce_ch
    import key_debouncer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int unsigned REPEAT_DELAY    = REP_DELAY_DEFAULT,
    parameter int unsigned REPEAT_PERIOD   = REP_PERIOD_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic key_sw_n,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_repeat
);

    localparam int DB_W  = cnt_width(DEBOUNCE_CYCLES);
    localparam int DL_W  = cnt_width(REPEAT_DELAY);
    localparam int PR_W  = cnt_width(REPEAT_PERIOD);
    localparam int RC_W  = (DL_W > PR_W) ? DL_W : PR_W;

    localparam logic [DB_W-1:0] DB_TC = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RC_W-1:0] DL_TC = RC_W'((REPEAT_DELAY == 0) ? 0 : REPEAT_DELAY - 1);
    localparam logic [RC_W-1:0] PR_TC = RC_W'(REPEAT_PERIOD - 1);

    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic            sync_k;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            level_q, level_d;
    logic            press_q, press_d;
    logic            release_q, release_d;
    logic            repeat_q, repeat_d;
    logic [RC_W-1:0] rpt_cnt_q, rpt_cnt_d;
    rpt_state_e      state_q, state_d;

    always_comb begin
        sync1_d  = key_sw_n;
        sync2_d  = sync1_q;
        sync_k   = ~sync2_q;

        level_d  = level_q;
        db_cnt_d = '0;
        if (sync_k != level_q) begin
            if (db_cnt_q == DB_TC) begin
                level_d = ~level_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end

        press_d   = level_d & ~level_q;
        release_d = ~level_d & level_q;

        // Release wins over a repeat that would land in the same cycle.
        state_d   = state_q;
        rpt_cnt_d = rpt_cnt_q;
        repeat_d  = 1'b0;
        if (release_d) begin
            state_d   = RELEASED;
            rpt_cnt_d = '0;
        end else begin
            case (state_q)
                RELEASED: begin
                    if (press_d) begin
                        repeat_d  = 1'b1;
                        rpt_cnt_d = '0;
                        if (REPEAT_DELAY != 0) state_d = HOLD_DELAY;
                    end
                end
                HOLD_DELAY: begin
                    if (rpt_cnt_q == DL_TC) begin
                        repeat_d  = 1'b1;
                        rpt_cnt_d = '0;
                        state_d   = HOLD_REPEAT;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + 1'b1;
                    end
                end
                HOLD_REPEAT: begin
                    if (rpt_cnt_q == PR_TC) begin
                        repeat_d  = 1'b1;
                        rpt_cnt_d = '0;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d   = RELEASED;
                    rpt_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            db_cnt_q  <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
            rpt_cnt_q <= '0;
            state_q   <= RELEASED;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            db_cnt_q  <= db_cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
            rpt_cnt_q <= rpt_cnt_d;
            state_q   <= state_d;
        end
    end

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign key_repeat  = repeat_q;

endmodule

// File: rtl/key_debouncer.sv
// Multi-key conditioner: N_KEYS independent debounced channels producing
// level, press/release pulses and an auto-repeat pulse stream.
module key_debouncer
    import key_debouncer_pkg::*;
#(
    parameter int unsigned N_KEYS          = 4,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int unsigned REPEAT_DELAY    = REP_DELAY_DEFAULT,
    parameter int unsigned REPEAT_PERIOD   = REP_PERIOD_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_KEYS-1:0] key_sw_n,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_repeat
);

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .key_sw_n    (key_sw_n[i]),
            .key_level   (key_level[i]),
            .key_press   (key_press[i]),
            .key_release (key_release[i]),
            .key_repeat  (key_repeat[i])
        );
    end

endmodule

// File: tb/tb_key_debouncer.sv
// Bench for key_debouncer: expected pulse events are queued with their cycle
// when keys are driven, and a negedge monitor pops and compares them.
module tb_key_debouncer;

    localparam int N   = 4;
    localparam int DEB = 4;
    localparam int RD  = 10;
    localparam int RP  = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] key_sw_n = '1;
    logic [N-1:0] key_level, key_press, key_release, key_repeat;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        int           at;
        logic [N-1:0] press;
        logic [N-1:0] rel;
        logic [N-1:0] rep;
    } ev_t;

    ev_t sb[$];

    key_debouncer #(
        .N_KEYS          (N),
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .key_sw_n    (key_sw_n),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_repeat  (key_repeat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input int at, input logic [N-1:0] p, input logic [N-1:0] r,
                        input logic [N-1:0] rp);
        ev_t e;
        e.at = at; e.press = p; e.rel = r; e.rep = rp;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (!reset) begin
            while (sb.size() > 0 && sb[0].at < cyc) begin
                e = sb.pop_front();
                chk("missed_event_cycle", cyc, e.at);
            end
            if (sb.size() > 0 && sb[0].at == cyc) begin
                e = sb.pop_front();
                chk("press", int'(key_press), int'(e.press));
                chk("release", int'(key_release), int'(e.rel));
                chk("repeat", int'(key_repeat), int'(e.rep));
            end else if (|{key_press, key_release, key_repeat}) begin
                chk("unexpected_pulse", int'({key_press, key_release, key_repeat}), 0);
            end
        end
    end

    // Hold key k low for low_cycles raw cycles, queueing the model's events.
    task automatic key_hold(input int k, input int low_cycles);
        int c0, p, r, t;
        logic [N-1:0] m;
        m = '0;
        m[k] = 1'b1;
        @(posedge clk); #1;
        c0 = cyc;
        key_sw_n[k] = 1'b0;
        if (low_cycles >= DEB) begin
            p = c0 + 2 + DEB;
            r = c0 + low_cycles + 2 + DEB;
            push(p, m, '0, m);
            t = p + RD;
            while (t < r) begin
                push(t, '0, '0, m);
                t += RP;
            end
            push(r, '0, m, '0);
        end
        repeat (low_cycles) @(posedge clk);
        #1;
        chk("level_before_release", int'(key_level[k]),
            (low_cycles >= DEB + 2) ? 1 : 0);
        key_sw_n[k] = 1'b1;
        repeat (DEB + 8) @(posedge clk);
    endtask

    initial begin
        int c0, c1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_level", int'(key_level), 0);
        chk("reset_press", int'(key_press), 0);
        chk("reset_release", int'(key_release), 0);
        chk("reset_repeat", int'(key_repeat), 0);
        reset = 1'b0;
        repeat (4) @(posedge clk);

        // clean press on key 0, released before any auto-repeat
        key_hold(0, 9);

        // bounce on key 1
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1; key_sw_n[1] = 1'b0;
            repeat (2) @(posedge clk); #1; key_sw_n[1] = 1'b1;
            repeat (1) @(posedge clk);
        end
        repeat (10) @(posedge clk);
        #1;
        chk("bounce_level", int'(key_level[1]), 0);

        // auto-repeat on key 2; a repeat would coincide with the release cycle
        key_hold(2, RD + 9 * RP);

        // glitch one cycle too short, then just long enough
        key_hold(3, DEB - 1);
        key_hold(3, DEB);

        // simultaneous press of all keys
        @(posedge clk); #1;
        c0 = cyc;
        key_sw_n = '0;
        push(c0 + 6, '1, '0, '1);
        push(c0 + 14, '0, '1, '0);
        repeat (8) @(posedge clk); #1;
        chk("all_level", int'(key_level), 15);
        key_sw_n = '1;
        repeat (14) @(posedge clk);

        // reset while key 2 is in HOLD_REPEAT
        @(posedge clk); #1;
        c0 = cyc;
        key_sw_n[2] = 1'b0;
        push(c0 + 6, 4'b0100, '0, 4'b0100);
        push(c0 + 16, '0, '0, 4'b0100);
        push(c0 + 19, '0, '0, 4'b0100);
        repeat (20) @(posedge clk);
        #1;
        chk("pre_reset_level", int'(key_level), 4);
        #1;
        reset = 1'b1;
        #1;
        chk("async_reset_level", int'(key_level), 0);
        chk("async_reset_pulses", int'({key_press, key_release, key_repeat}), 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        c1 = cyc;
        push(c1 + 6, 4'b0100, '0, 4'b0100);
        push(c1 + 14, '0, 4'b0100, '0);
        repeat (8) @(posedge clk);
        #1;
        key_sw_n[2] = 1'b1;
        repeat (14) @(posedge clk);

        #1;
        chk("scoreboard_drained", sb.size(), 0);
        chk("final_level", int'(key_level), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
